div_sequencer: RTL

Multi-cycle integer divide controller for the EX stage, covering RV32M DIV/DIVU/REM/REMU. It takes forwarded operands from the execute stage and runs a 32-iteration restoring shift-subtract divide. While the divide runs it holds the pipeline through a stall output, then returns the result for one cycle. Branch-flush squash and the RISC-V divide corner cases are handled inside the block.

---
 rtl/div_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle RV32M divide/remainder controller for the EX stage
//
// Runs a 32-iteration restoring shift-subtract divide for DIV/DIVU/REM/REMU and
// stalls the front of the pipeline while it works. Divide-by-zero and signed
// overflow are resolved at accept time and finish one cycle later.
//
// Ports:
//   clk              clock, rising edge
//   rst              synchronous active-high reset
//   start_in         EX holds a valid divide op
//   funct3_in        100 DIV, 101 DIVU, 110 REM, 111 REMU (sampled on accept)
//   op_a_in          dividend (forwarded)
//   op_b_in          divisor (forwarded)
//   flush_in         EX squash; aborts any op, wins over start_in
//   stall_out        holds PC, IF/ID, ID/EX (combinational)
//   busy_out         high in BUSY or DONE
//   result_out       registered quotient or remainder, updated only on entering DONE
//   result_valid_out one-cycle pulse in DONE

module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_in,
  input  logic [2:0]      funct3_in,
  input  logic [XLEN-1:0] op_a_in,
  input  logic [XLEN-1:0] op_b_in,
  input  logic            flush_in,
  output logic            stall_out,
  output logic            busy_out,
  output logic [XLEN-1:0] result_out,
  output logic            result_valid_out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  logic [4:0]      cnt;
  logic            is_rem;
  logic            neg_quo;
  logic            neg_rem;
  logic [XLEN-1:0] dvd;   // dividend magnitude; quotient bits shift in at the bottom
  logic [XLEN-1:0] dsr;   // divisor magnitude
  logic [XLEN-1:0] rem;   // partial remainder

  // funct3[2] is always 1 for ops that reach this block; it carries no information here.
  logic unused_funct3_bit;
  assign unused_funct3_bit = funct3_in[2];

  // Accept-time decode
  logic            acc_signed;
  logic            acc_rem;
  logic            a_neg;
  logic            b_neg;
  logic            div_zero;
  logic            overflow;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] special_res;

  always_comb begin
    acc_signed  = ~funct3_in[0];
    acc_rem     = funct3_in[1];
    a_neg       = acc_signed & op_a_in[XLEN-1];
    b_neg       = acc_signed & op_b_in[XLEN-1];
    a_mag       = a_neg ? -op_a_in : op_a_in;
    b_mag       = b_neg ? -op_b_in : op_b_in;
    div_zero    = (op_b_in == '0);
    overflow    = acc_signed & (op_a_in == MOST_NEG) & (op_b_in == '1);
    special_res = '0;
    if (div_zero)
      special_res = acc_rem ? op_a_in : '1;
    else if (overflow)
      special_res = acc_rem ? '0 : MOST_NEG;
  end

  // One restoring iteration. The extra top bit of the difference is the borrow:
  // clear borrow means the shifted remainder covers the divisor.
  logic [XLEN-1:0] rem_shift;
  logic [XLEN:0]   diff;
  logic            take;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] final_res;

  always_comb begin
    rem_shift = {rem[XLEN-2:0], dvd[XLEN-1]};
    diff      = {1'b0, rem_shift} - {1'b0, dsr};
    take      = ~diff[XLEN];
    rem_next  = take ? diff[XLEN-1:0] : rem_shift;
    quo_next  = {dvd[XLEN-2:0], take};
    quo_fix   = neg_quo ? -quo_next : quo_next;
    rem_fix   = neg_rem ? -rem_next : rem_next;
    final_res = is_rem ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      result_out       <= '0;
      result_valid_out <= 1'b0;
    end else if (flush_in) begin
      // Squash: drop whatever is in flight, leave result_out alone.
      state            <= IDLE;
      result_valid_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          result_valid_out <= 1'b0;
          if (start_in) begin
            is_rem  <= acc_rem;
            neg_quo <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            dvd     <= a_mag;
            dsr     <= b_mag;
            rem     <= '0;
            cnt     <= '0;
            if (div_zero || overflow) begin
              result_out       <= special_res;
              result_valid_out <= 1'b1;
              state            <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          dvd <= quo_next;
          rem <= rem_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            result_out       <= final_res;
            result_valid_out <= 1'b1;
            state            <= DONE;
          end
        end
        DONE: begin
          // The op in EX advances this cycle, so never re-accept it.
          result_valid_out <= 1'b0;
          state            <= IDLE;
        end
        default: begin
          result_valid_out <= 1'b0;
          state            <= IDLE;
        end
      endcase
    end
  end

  assign stall_out = start_in & (state != DONE) & ~flush_in;
  assign busy_out  = (state != IDLE);

endmodule
